lsu_ctrl: RTL

//  Load/store initiator in the MEM stage; drives the word-only DMEM port (aligned, word RSel/WSel).

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, DMEM select codes,
// controller state encoding and access-size helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] RSEL_W   = 3'b010;
    localparam logic [2:0] RSEL_NOP = 3'b111;
    localparam logic [1:0] WSEL_W   = 2'b10;
    localparam logic [1:0] WSEL_NOP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_WR0,
        ST_WR1,
        ST_DONE
    } lsu_state_t;

    // Access size in bytes (1, 2 or 4) from the low funct3 bits.
    function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores only know SB/SH/SW; loads additionally have the unsigned forms.
    function automatic logic is_bad_funct3(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 >= 3'b011);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic over a two-word window: load extract/extend
// and store-data merge at an arbitrary byte offset.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [63:0] merged
);

    logic [2:0]  size;
    logic [31:0] shifted;
    logic        sext;

    assign size = size_bytes(funct3[1:0]);
    assign sext = ~funct3[2];

    always_comb begin
        shifted = 32'(window >> {offset, 3'b000});
        case (funct3[1:0])
            2'b00:   load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Each window lane takes a store byte when it falls inside [offset, offset+size).
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [3:0] LANE = 4'(gi);
            logic [3:0] rel;
            logic       hit;
            logic [7:0] wbyte;

            always_comb begin
                rel   = LANE - {2'b00, offset};
                hit   = (LANE >= {2'b00, offset}) && (rel < {1'b0, size});
                wbyte = wdata[{rel[1:0], 3'b000} +: 8];
            end

            assign merged[8*gi +: 8] = hit ? wbyte : window[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store initiator: converts any-size, any-alignment accesses into
// aligned word reads/writes on DMEM, using read-modify-write for partial stores.
module lsu_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [1:0]            dm_wsel,
    output logic [2:0]            dm_rsel,
    output logic                  dm_memrw,
    input  logic [DATA_WIDTH-1:0] dm_rdata
);
    import lsu_pkg::*;

    lsu_state_t state_reg, state_next;

    logic                  we_reg;
    logic [2:0]            funct3_reg;
    logic [DATA_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] buf0_reg;
    logic [DATA_WIDTH-1:0] buf1_reg;

    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] dm_addr_reg;
    logic [DATA_WIDTH-1:0] dm_wdata_reg;
    logic [1:0]            dm_wsel_reg;
    logic [2:0]            dm_rsel_reg;
    logic                  dm_memrw_reg;

    logic                  cur_we;
    logic [2:0]            cur_funct3;
    logic [DATA_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [2:0]            size_b;
    logic [1:0]            offset;
    logic                  span;
    logic                  illegal;
    logic                  accept;
    logic [DATA_WIDTH-1:0] w0;
    logic [DATA_WIDTH-1:0] w1;
    logic [2*DATA_WIDTH-1:0] window_next;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [2*DATA_WIDTH-1:0] merged;

    // In IDLE the live request drives the decode so the first state's outputs
    // can be registered on the accept edge itself.
    always_comb begin
        if (state_reg == ST_IDLE) begin
            cur_we     = req_we;
            cur_funct3 = req_funct3;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = we_reg;
            cur_funct3 = funct3_reg;
            cur_addr   = addr_reg;
            cur_wdata  = wdata_reg;
        end
    end

    assign size_b  = size_bytes(cur_funct3[1:0]);
    assign offset  = cur_addr[1:0];
    assign span    = ({1'b0, offset} + size_b) > 3'd4;
    assign illegal = is_bad_funct3(cur_we, cur_funct3) || (span && !ALLOW_MISALIGNED);
    assign accept  = (state_reg == ST_IDLE) && req_valid;
    assign w0      = {cur_addr[DATA_WIDTH-1:2], 2'b00};
    assign w1      = w0 + DATA_WIDTH'(4);

    // The word being read this cycle is forwarded so results/merges are ready
    // at the same edge that captures it.
    always_comb begin
        window_next = {buf1_reg, buf0_reg};
        if (state_reg == ST_RD0)
            window_next[DATA_WIDTH-1:0] = dm_rdata;
        if (state_reg == ST_RD1)
            window_next[2*DATA_WIDTH-1:DATA_WIDTH] = dm_rdata;
    end

    lsu_align u_align (
        .window    (window_next),
        .offset    (offset),
        .funct3    (cur_funct3),
        .wdata     (cur_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid && !illegal) begin
                    if (cur_we && size_b == 3'd4 && offset == 2'b00)
                        state_next = ST_WR0;
                    else
                        state_next = ST_RD0;
                end
            end
            ST_RD0: begin
                if (span)
                    state_next = ST_RD1;
                else if (cur_we)
                    state_next = ST_WR0;
                else
                    state_next = ST_DONE;
            end
            ST_RD1:  state_next = cur_we ? ST_WR0 : ST_DONE;
            ST_WR0:  state_next = span ? ST_WR1 : ST_DONE;
            ST_WR1:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            buf0_reg      <= '0;
            buf1_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            err_reg       <= 1'b0;
            dm_addr_reg   <= '0;
            dm_wdata_reg  <= '0;
            dm_wsel_reg   <= WSEL_NOP;
            dm_rsel_reg   <= RSEL_NOP;
            dm_memrw_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
            end
            if (state_reg == ST_RD0)
                buf0_reg <= dm_rdata;
            if (state_reg == ST_RD1)
                buf1_reg <= dm_rdata;

            rsp_valid_reg <= (state_next == ST_DONE);
            err_reg       <= accept && illegal;
            if (state_next == ST_DONE && !cur_we)
                rsp_rdata_reg <= load_data;

            // DMEM controls are registered from the next state so they line up with it.
            case (state_next)
                ST_RD0: begin
                    dm_addr_reg  <= w0;
                    dm_rsel_reg  <= RSEL_W;
                    dm_wsel_reg  <= WSEL_NOP;
                    dm_memrw_reg <= 1'b0;
                end
                ST_RD1: begin
                    dm_addr_reg  <= w1;
                    dm_rsel_reg  <= RSEL_W;
                    dm_wsel_reg  <= WSEL_NOP;
                    dm_memrw_reg <= 1'b0;
                end
                ST_WR0: begin
                    dm_addr_reg  <= w0;
                    dm_wdata_reg <= merged[DATA_WIDTH-1:0];
                    dm_rsel_reg  <= RSEL_NOP;
                    dm_wsel_reg  <= WSEL_W;
                    dm_memrw_reg <= 1'b1;
                end
                ST_WR1: begin
                    dm_addr_reg  <= w1;
                    dm_wdata_reg <= merged[2*DATA_WIDTH-1:DATA_WIDTH];
                    dm_rsel_reg  <= RSEL_NOP;
                    dm_wsel_reg  <= WSEL_W;
                    dm_memrw_reg <= 1'b1;
                end
                default: begin
                    dm_rsel_reg  <= RSEL_NOP;
                    dm_wsel_reg  <= WSEL_NOP;
                    dm_memrw_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign err       = err_reg;
    assign dm_addr   = dm_addr_reg;
    assign dm_wdata  = dm_wdata_reg;
    assign dm_wsel   = dm_wsel_reg;
    assign dm_rsel   = dm_rsel_reg;
    assign dm_memrw  = dm_memrw_reg;

endmodule
